// File: rtl/alu_result_uart_tx_if.sv
// Bundles the ALU-result capture inputs and the UART/FIFO status outputs of alu_result_uart_tx.
// The slave modport is the design side; the master modport is the CPU/observer side.
interface alu_result_uart_tx_if;
  logic [31:0] cpu_output;
  logic        capture_en;
  logic        fifo_full;
  logic        fifo_empty;
  logic [15:0] dropped_count;
  logic        busy;
  logic        uart_tx;

  modport master (
    output cpu_output,
    output capture_en,
    input  fifo_full,
    input  fifo_empty,
    input  dropped_count,
    input  busy,
    input  uart_tx
  );

  modport slave (
    input  cpu_output,
    input  capture_en,
    output fifo_full,
    output fifo_empty,
    output dropped_count,
    output busy,
    output uart_tx
  );
endinterface

// File: rtl/alu_result_uart_tx.sv
// Buffers captured 32-bit ALU results in a FIFO and sends each as four 8N1 bytes, MSB byte first.
// Line falls one edge after the push into an empty FIFO; full-FIFO captures are counted, never stalled.
module alu_result_uart_tx #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input logic                 clk,
  input logic                 reset,
  alu_result_uart_tx_if.slave bus
);

  localparam int unsigned      AW        = $clog2(DEPTH);
  localparam int unsigned      BW        = $clog2(CLKS_PER_BIT);
  localparam logic [AW:0]      FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [BW-1:0]    BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;

  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [2:0]    byte_q, byte_d;
  logic [31:0]   shreg_q, shreg_d;
  logic          tx_q, tx_d;

  logic          full;
  logic          empty;
  logic          push;
  logic          drop;
  logic          pop;
  logic [7:0]    cur_byte;

  // Full is the pre-edge occupancy, so a push coinciding with a pop from a full FIFO is dropped.
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign push  = bus.capture_en && !full;
  assign drop  = bus.capture_en && full;
  assign pop   = (state_q == S_IDLE) && !empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= bus.cpu_output;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shreg_d = shreg_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d = S_START;
          baud_d  = '0;
          bit_d   = '0;
          byte_d  = '0;
          shreg_d = mem_q[rd_ptr_q];
        end
      end
      S_START: begin
        if (baud_q == BAUD_LAST) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          byte_d = byte_q + 3'd1;
          if ((byte_q + 3'd1) < 3'd4) begin
            state_d = S_START;
            shreg_d = {shreg_q[23:0], 8'h00};
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level is derived from the next state so it changes on the same edge as the state.
  assign cur_byte = shreg_d[31:24];

  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = cur_byte[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  assign bus.fifo_full     = full;
  assign bus.fifo_empty    = empty;
  assign bus.dropped_count = drop_cnt_q;
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.uart_tx       = tx_q;

endmodule
